// File: rtl/send_422_frame.sv
// send_422_frame
//   RS-422 feedback frame transmitter for the lidar control link. Latches an
//   NBYTES payload on a valid/ready handshake, then sends HEADER, the payload
//   bytes (byte 0 = MSB byte first) and, when SEND_422_CHKSUM_EN is defined,
//   an 8-bit additive checksum of the payload. Bytes are sent one at a time
//   through a uart_tx_even_check child (8 data bits, even parity, 1 stop bit).
//
//   Optional feature macro: SEND_422_CHKSUM_EN (appends the checksum byte).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   frame_data   payload, byte k = frame_data[8*NBYTES-1-8k -: 8]
//   frame_valid  request to send frame_data
//   frame_ready  frame can be accepted (IDLE only)
//   TXD          serial line, idles high
//   txd_done     one-cycle pulse after the last byte of a frame
//   frame_cnt    completed frame count, wraps at 16 bits
//
// Parameters
//   NBYTES        payload bytes per frame, 1..16
//   HEADER        first byte of every frame
//   CLKS_PER_BIT  clocks per serial bit in the UART child

module send_422_frame #(
    parameter int          NBYTES       = 2,
    parameter logic [7:0]  HEADER       = 8'hEB,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*NBYTES-1:0]   frame_data,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic                  TXD,
    output logic                  txd_done,
    output logic [15:0]           frame_cnt
);

    // state   | meaning
    // --------+-----------------------------------------------------------
    // S_IDLE  | waiting for frame_valid, frame_ready high
    // S_ISSUE | one-cycle tx_data_valid strobe for the current byte
    // S_WAIT  | byte on the line, waiting for the child's tx_data_ready
    // S_DONE  | txd_done pulse, frame_cnt already shows the new value

`ifdef SEND_422_CHKSUM_EN
    localparam int LEN = NBYTES + 2;
`else
    localparam int LEN = NBYTES + 1;
`endif
    localparam int                IDX_W    = $clog2(NBYTES + 2);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [IDX_W-1:0]  PAY_LAST = IDX_W'(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [IDX_W-1:0]     idx;
    logic [8*NBYTES-1:0]  shadow;
    logic                 rst_done;     // holds frame_ready low until the first clock after reset

    logic [7:0]           tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ready;

    logic                 accept;
    logic                 step;
    logic                 finish;
    logic                 is_payload;
    logic [7:0]           payload_byte;
    logic [7:0]           cur_byte;

`ifdef SEND_422_CHKSUM_EN
    logic [7:0]           chk;
`endif

    assign is_payload = (idx != '0) && (idx <= PAY_LAST);

    // Index 0 is the header, 1..NBYTES select payload bytes from the shadow
    // copy, and the index after the payload carries the checksum.
    always_comb begin
        payload_byte = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == IDX_W'(k + 1)) begin
                payload_byte = shadow[8*(NBYTES-1-k) +: 8];
            end
        end
        if (idx == '0) begin
            cur_byte = HEADER;
        end else if (is_payload) begin
            cur_byte = payload_byte;
        end else begin
`ifdef SEND_422_CHKSUM_EN
            cur_byte = chk;
`else
            cur_byte = 8'h00;
`endif
        end
    end

    always_comb begin
        next_state    = state;
        frame_ready   = 1'b0;
        tx_data_valid = 1'b0;
        tx_data       = 8'h00;
        txd_done      = 1'b0;
        accept        = 1'b0;
        step          = 1'b0;
        finish        = 1'b0;
        case (state)
            S_IDLE: begin
                frame_ready = rst_done;
                if (frame_valid && rst_done) begin
                    accept     = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_data_valid = 1'b1;
                tx_data       = cur_byte;
                next_state    = S_WAIT;
            end
            S_WAIT: begin
                if (tx_data_ready) begin
                    if (idx == LAST_IDX) begin
                        finish     = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        step       = 1'b1;
                        next_state = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                txd_done   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rst_done  <= 1'b0;
            idx       <= '0;
            shadow    <= '0;
            frame_cnt <= 16'h0000;
        end else begin
            state    <= next_state;
            rst_done <= 1'b1;
            if (accept) begin
                shadow <= frame_data;
                idx    <= '0;
            end else if (step) begin
                idx <= idx + 1'b1;
            end
            // Updated on entry to DONE so the count is current alongside txd_done.
            if (finish) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef SEND_422_CHKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk <= 8'h00;
        end else if (accept) begin
            chk <= 8'h00;
        end else if ((state == S_ISSUE) && is_payload) begin
            chk <= chk + cur_byte;
        end
    end
`endif

    uart_tx_even_check #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .txd           (TXD)
    );

endmodule

// uart_tx_even_check
//   Byte transmitter: start bit, 8 data bits LSB first, even parity, stop bit.
//   Each bit lasts CLKS_PER_BIT clocks, timed by a down-counter.
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   tx_data        byte to send, sampled on tx_data_valid
//   tx_data_valid  single-cycle start strobe, ignored while busy
//   tx_data_ready  single-cycle pulse after the stop bit has finished
//   txd            serial output, idles high

module uart_tx_even_check #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_data_valid,
    output logic        tx_data_ready,
    output logic        txd
);

    localparam int             TW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  TC_LOAD = TW'(CLKS_PER_BIT - 1);

    logic           busy;
    logic [9:0]     shreg;      // {stop, parity, data[7:0]} still to go out
    logic [3:0]     bits_left;
    logic [TW-1:0]  timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            shreg         <= '0;
            bits_left     <= 4'd0;
            timer         <= '0;
            txd           <= 1'b1;
            tx_data_ready <= 1'b0;
        end else begin
            tx_data_ready <= 1'b0;
            if (!busy) begin
                if (tx_data_valid) begin
                    busy      <= 1'b1;
                    txd       <= 1'b0;
                    shreg     <= {1'b1, ^tx_data, tx_data};
                    bits_left <= 4'd10;
                    timer     <= TC_LOAD;
                end
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end else if (bits_left != 4'd0) begin
                txd       <= shreg[0];
                shreg     <= {1'b0, shreg[9:1]};
                bits_left <= bits_left - 4'd1;
                timer     <= TC_LOAD;
            end else begin
                busy          <= 1'b0;
                txd           <= 1'b1;
                tx_data_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_send_422_frame.sv
// Bench for send_422_frame: one NBYTES=2 and one NBYTES=4 instance share the
// clock and reset. Serial lines are decoded independently and compared with a
// byte-list model; frame timing is checked against the handshake latencies.

module tb_send_422_frame;

    localparam int CPB     = 4;
    localparam int T_CHILD = 11 * CPB + 1;   // child: strobe to tx_data_ready
`ifdef SEND_422_CHKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int L0 = 2 + 1 + CK;
    localparam int L1 = 4 + 1 + CK;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fd0 = 16'h0000;
    logic        fv0 = 1'b0;
    logic        fr0, txd0, done0;
    logic [15:0] cnt0;
    logic [31:0] fd1 = 32'h0;
    logic        fv1 = 1'b0;
    logic        fr1, txd1, done1;
    logic [15:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bq_t rx0, rx1;
    int done_n[2];
    int done_c0[$];
    int fmt_err[2];
    int exp_cnt[2];
    logic       mon_act[2];
    int         mon_cnt[2];
    logic [10:0] mon_bits[2];

    send_422_frame #(.NBYTES(2), .HEADER(8'hEB), .CLKS_PER_BIT(CPB)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_data(fd0), .frame_valid(fv0),
        .frame_ready(fr0), .TXD(txd0), .txd_done(done0), .frame_cnt(cnt0));

    send_422_frame #(.NBYTES(4), .HEADER(8'hEB), .CLKS_PER_BIT(CPB)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_data(fd1), .frame_valid(fv1),
        .frame_ready(fr1), .TXD(txd1), .txd_done(done1), .frame_cnt(cnt1));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line decoders, sampling mid-bit relative to the first low sample.
    initial begin
        logic       ln;
        int         j;
        logic [7:0] db;
        done_n[0] = 0; done_n[1] = 0; fmt_err[0] = 0; fmt_err[1] = 0;
        mon_act[0] = 1'b0; mon_act[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_act[0] = 1'b0;
                mon_act[1] = 1'b0;
            end else begin
                for (int ch = 0; ch < 2; ch++) begin
                    ln = (ch == 0) ? txd0 : txd1;
                    if (!mon_act[ch]) begin
                        if (ln === 1'b0) begin
                            mon_act[ch] = 1'b1;
                            mon_cnt[ch] = 0;
                        end
                    end else begin
                        mon_cnt[ch]++;
                        if (mon_cnt[ch] % CPB == CPB / 2) begin
                            j = mon_cnt[ch] / CPB;
                            mon_bits[ch][j] = ln;
                            if (j == 10) begin
                                db = mon_bits[ch][8:1];
                                if (mon_bits[ch][0] !== 1'b0 || mon_bits[ch][10] !== 1'b1 ||
                                    (^mon_bits[ch][9:1]) !== 1'b0)
                                    fmt_err[ch]++;
                                if (ch == 0) rx0.push_back(db);
                                else         rx1.push_back(db);
                                mon_act[ch] = 1'b0;
                            end
                        end
                    end
                end
                if (done0 === 1'b1) begin
                    done_n[0]++;
                    done_c0.push_back(cyc);
                end
                if (done1 === 1'b1) done_n[1]++;
            end
        end
    end

    function automatic bq_t model_bytes(int nb, logic [31:0] d);
        bq_t q;
        logic [7:0] s;
        logic [7:0] b;
        q = {};
        s = 8'h00;
        q.push_back(8'hEB);
        for (int k = 0; k < nb; k++) begin
            b = d[8*(nb-1-k) +: 8];
            s = s + b;
            q.push_back(b);
        end
        if (CK == 1) q.push_back(s);
        return q;
    endfunction

    function automatic bit same_bytes(bq_t a, bq_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q2s(bq_t q);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    // Waits for frame_ready, presents one frame for one cycle, then waits for
    // its txd_done. t0 is the accept cycle.
    task automatic drive_frame(input int ch, input logic [31:0] data,
                               output int t0, output bit tmo, output logic rdy_after);
        int w;
        int base;
        tmo = 1'b0;
        w = 0;
        while ((((ch == 0) ? fr0 : fr1) !== 1'b1) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        if (ch == 0) begin fd0 = data[15:0]; fv0 = 1'b1; rx0 = {}; end
        else         begin fd1 = data;       fv1 = 1'b1; rx1 = {}; end
        t0 = cyc;
        base = done_n[ch];
        @(negedge clk);
        rdy_after = (ch == 0) ? fr0 : fr1;
        fv0 = 1'b0;
        fv1 = 1'b0;
        w = 0;
        while (done_n[ch] == base && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (done_n[ch] == base) tmo = 1'b1;
        else exp_cnt[ch]++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        n_checks++;
        if (fr0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", fr0); end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (fr0 !== 1'b1 || fr1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b%b want 11", fr0, fr1); end
        n_checks++;
        if (txd0 !== 1'b1 || txd1 !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b%b want 11", txd0, txd1); end
        n_checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b%b want 00", done0, done1); end
        n_checks++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %h %h want 0", cnt0, cnt1); end
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (dut0.tx_data_valid !== 1'b0 || dut1.tx_data_valid !== 1'b0 ||
                txd0 !== 1'b1 || txd1 !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_basic_1234();
        int t0; bit tmo; logic ra; int d0; bq_t exp;
        d0 = done_n[0];
        drive_frame(0, 32'h1234, t0, tmo, ra);
        exp = model_bytes(2, 32'h1234);
        n_checks++;
        if (tmo) begin n_fail++; $display("FAIL basic_timeout: got no txd_done want one"); end
        n_checks++;
        if (ra !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b want 0", ra); end
        n_checks++;
        if (!same_bytes(rx0, exp)) begin n_fail++; $display("FAIL basic_bytes: got %s want %s", q2s(rx0), q2s(exp)); end
        n_checks++;
        if (fmt_err[0] != 0) begin n_fail++; $display("FAIL basic_parity: got %0d bad bytes want 0", fmt_err[0]); end
        n_checks++;
        if (done_n[0] - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_n[0] - d0); end
        n_checks++;
        if (done_c0.size() == 0 || done_c0[$] - t0 != L0 * (T_CHILD + 1) + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d",
                     (done_c0.size() == 0) ? -1 : done_c0[$] - t0, L0 * (T_CHILD + 1) + 1);
        end
        n_checks++;
        if (cnt0 !== 16'(exp_cnt[0])) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", cnt0, exp_cnt[0]); end
    endtask

    task automatic test_wrap();
        int t0; bit tmo; logic ra; bq_t exp;
        drive_frame(1, 32'hFFFFFF03, t0, tmo, ra);
        exp = model_bytes(4, 32'hFFFFFF03);
        n_checks++;
        if (tmo) begin n_fail++; $display("FAIL wrap_timeout: got no txd_done want one"); end
        n_checks++;
        if (!same_bytes(rx1, exp)) begin n_fail++; $display("FAIL wrap_bytes: got %s want %s", q2s(rx1), q2s(exp)); end
        n_checks++;
        if (fmt_err[1] != 0) begin n_fail++; $display("FAIL wrap_parity: got %0d bad bytes want 0", fmt_err[1]); end
        n_checks++;
        if (cnt1 !== 16'(exp_cnt[1])) begin n_fail++; $display("FAIL wrap_cnt: got %0d want %0d", cnt1, exp_cnt[1]); end
    endtask

    task automatic test_ignore_busy();
        int w; int d0; bq_t exp;
        w = 0;
        while (fr0 !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        @(negedge clk);
        fd0 = 16'h1234; fv0 = 1'b1; rx0 = {};
        d0 = done_n[0];
        @(negedge clk);
        fv0 = 1'b0;
        repeat (60) @(negedge clk);
        fd0 = 16'hAAAA; fv0 = 1'b1;
        repeat (5) @(negedge clk);
        fv0 = 1'b0;
        w = 0;
        while (done_n[0] == d0 && w < 3000) begin @(negedge clk); w++; end
        if (done_n[0] != d0) exp_cnt[0]++;
        repeat (400) @(negedge clk);
        exp = model_bytes(2, 32'h1234);
        n_checks++;
        if (!same_bytes(rx0, exp)) begin n_fail++; $display("FAIL ignore_bytes: got %s want %s", q2s(rx0), q2s(exp)); end
        n_checks++;
        if (done_n[0] - d0 != 1) begin n_fail++; $display("FAIL ignore_frames: got %0d want 1", done_n[0] - d0); end
        n_checks++;
        if (cnt0 !== 16'(exp_cnt[0])) begin n_fail++; $display("FAIL ignore_cnt: got %0d want %0d", cnt0, exp_cnt[0]); end
    endtask

    task automatic test_random();
        int t0; bit tmo; logic ra; bq_t exp; logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            drive_frame(i % 2, d, t0, tmo, ra);
            exp = (i % 2 == 0) ? model_bytes(2, d) : model_bytes(4, d);
            n_checks++;
            if (tmo) begin n_fail++; $display("FAIL rand_timeout[%0d]: got no txd_done want one", i); end
            n_checks++;
            if (i % 2 == 0) begin
                if (!same_bytes(rx0, exp)) begin n_fail++; $display("FAIL rand_bytes[%0d]: got %s want %s", i, q2s(rx0), q2s(exp)); end
            end else begin
                if (!same_bytes(rx1, exp)) begin n_fail++; $display("FAIL rand_bytes[%0d]: got %s want %s", i, q2s(rx1), q2s(exp)); end
            end
        end
        n_checks++;
        if (cnt0 !== 16'(exp_cnt[0]) || cnt1 !== 16'(exp_cnt[1])) begin
            n_fail++;
            $display("FAIL rand_cnt: got %0d %0d want %0d %0d", cnt0, cnt1, exp_cnt[0], exp_cnt[1]);
        end
        n_checks++;
        if (fmt_err[0] != 0 || fmt_err[1] != 0) begin n_fail++; $display("FAIL rand_parity: got %0d %0d want 0 0", fmt_err[0], fmt_err[1]); end
    endtask

    task automatic test_back_to_back();
        int w; int k; int d0; int nd; bq_t exp; bq_t one; logic [15:0] d;
        d = 16'($urandom);
        one = model_bytes(2, {16'h0, d});
        exp = {};
        for (int i = 0; i < 3; i++) foreach (one[b]) exp.push_back(one[b]);
        w = 0;
        while (fr0 !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        @(negedge clk);
        fd0 = d; fv0 = 1'b1; rx0 = {};
        d0 = done_n[0];
        k = 0; w = 0;
        while (k < 3 && w < 5000) begin
            @(negedge clk);
            w++;
            if (done0 === 1'b1) k++;
        end
        fv0 = 1'b0;
        n_checks++;
        if (k != 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d frames want 3", k); end
        repeat (400) @(negedge clk);
        nd = done_n[0] - d0;
        exp_cnt[0] += nd;
        n_checks++;
        if (nd != 3) begin n_fail++; $display("FAIL b2b_frames: got %0d want 3", nd); end
        n_checks++;
        if (!same_bytes(rx0, exp)) begin n_fail++; $display("FAIL b2b_bytes: got %s want %s", q2s(rx0), q2s(exp)); end
        if (done_c0.size() >= 3) begin
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (done_c0[done_c0.size()-3+i] - done_c0[done_c0.size()-4+i] != L0 * (T_CHILD + 1) + 2) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i,
                             done_c0[done_c0.size()-3+i] - done_c0[done_c0.size()-4+i], L0 * (T_CHILD + 1) + 2);
                end
            end
        end
        n_checks++;
        if (cnt0 !== 16'(exp_cnt[0])) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", cnt0, exp_cnt[0]); end
    endtask

    task automatic test_reset_abort();
        int w; int d0; int t0; bit tmo; logic ra; bq_t exp; logic [15:0] d;
        w = 0;
        while (fr0 !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        @(negedge clk);
        fd0 = 16'($urandom); fv0 = 1'b1;
        @(negedge clk);
        fv0 = 1'b0;
        repeat (T_CHILD + 12) @(negedge clk);
        d0 = done_n[0];
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (txd0 !== 1'b1) begin n_fail++; $display("FAIL abort_txd: got %b want 1", txd0); end
        n_checks++;
        if (cnt0 !== 16'd0 || done0 !== 1'b0) begin n_fail++; $display("FAIL abort_cnt_done: got %0d %b want 0 0", cnt0, done0); end
        rst_n = 1'b1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        repeat (400) @(negedge clk);
        n_checks++;
        if (done_n[0] != d0 || txd0 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d dones txd %b want 0 dones txd 1", done_n[0] - d0, txd0);
        end
        d = 16'($urandom);
        drive_frame(0, {16'h0, d}, t0, tmo, ra);
        exp = model_bytes(2, {16'h0, d});
        n_checks++;
        if (tmo) begin n_fail++; $display("FAIL abort_next_timeout: got no txd_done want one"); end
        n_checks++;
        if (!same_bytes(rx0, exp)) begin n_fail++; $display("FAIL abort_next_bytes: got %s want %s", q2s(rx0), q2s(exp)); end
        n_checks++;
        if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL abort_next_cnt: got %0d want 1", cnt0); end
    endtask

    initial begin
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        test_reset();
        test_basic_1234();
        test_wrap();
        test_ignore_busy();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion want completion within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
